// File: rtl/demux4_frame.sv
// demux4_frame: 1-to-4 lane demux with direct (sel) and auto (rotating pointer, framed) routing.
// Define DEMUX_FRAME_CNT_EN to add the 8-bit frame_cnt output counting completed frames.
module demux4_frame #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  input  logic             mode,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic [1:0]       lane_ptr,
  output logic             frame_done
`ifdef DEMUX_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t r_state, w_state;
  logic [1:0] r_ptr, w_ptr, w_lane;
  logic [3:0] r_valid;
  logic r_done, w_done;
  logic [WIDTH-1:0] r_lane [4];
  always_comb begin
    w_state = r_state;
    w_ptr = r_ptr;
    w_done = 1'b0;
    w_lane = mode ? r_ptr : sel;
    case (r_state)
      IDLE: if (mode && in_valid) begin
        w_state = FILL;
        w_ptr = 2'd1;
      end
      FILL: if (!mode) begin
        // leaving auto mode drops the partial frame; written lanes keep their data
        w_state = IDLE;
        w_ptr = 2'd0;
      end else if (in_valid) begin
        w_ptr = r_ptr + 2'd1;
        w_done = r_ptr == 2'd3;
        w_state = w_done ? IDLE : FILL;
      end
      default: begin
        w_state = IDLE;
        w_ptr = 2'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= 2'd0;
      r_valid <= 4'd0;
      r_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_lane[i] <= '0;
    end else begin
      r_state <= w_state;
      r_ptr <= w_ptr;
      r_valid <= in_valid ? 4'b0001 << w_lane : 4'd0;
      r_done <= w_done;
      if (in_valid) r_lane[w_lane] <= in_data;
    end
  end
`ifdef DEMUX_FRAME_CNT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= 8'd0;
    else r_cnt <= r_cnt + {7'd0, w_done};
  end
  assign frame_cnt = r_cnt;
`endif
  assign out0 = r_lane[0];
  assign out1 = r_lane[1];
  assign out2 = r_lane[2];
  assign out3 = r_lane[3];
  assign out_valid = r_valid;
  assign lane_ptr = r_ptr;
  assign frame_done = r_done;
endmodule

// File: tb/tb_demux4_frame.sv
// tb_demux4_frame: table-driven vectors with a queue scoreboard, plus a long frame loop for counter wrap.
module tb_demux4_frame;
  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, mode = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [1:0] sel = 2'd0;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic [1:0] lane_ptr;
  logic frame_done;
`ifdef DEMUX_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif
  always #5 clk = ~clk;
  demux4_frame #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel), .mode(mode),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .lane_ptr(lane_ptr), .frame_done(frame_done)
`ifdef DEMUX_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  typedef struct {
    logic rst, v, m;
    logic [1:0] sel;
    logic [7:0] d;
    logic [31:0] lanes;
    logic [3:0] ov;
    logic fd;
    logic [1:0] lp;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  function automatic void add(input logic r, input logic v, input logic m, input logic [1:0] s,
                              input logic [7:0] d, input logic [31:0] lanes, input logic [3:0] ov,
                              input logic fd, input logic [1:0] lp);
    vec_t e;
    e.rst = r; e.v = v; e.m = m; e.sel = s; e.d = d;
    e.lanes = lanes; e.ov = ov; e.fd = fd; e.lp = lp;
    tbl.push_back(e);
  endfunction
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; in_valid = v.v; mode = v.m; sel = v.sel; in_data = v.d;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("lanes", idx, {out3, out2, out1, out0}, e.lanes);
    chk("out_valid", idx, 32'(out_valid), 32'(e.ov));
    chk("frame_done", idx, 32'(frame_done), 32'(e.fd));
    chk("lane_ptr", idx, 32'(lane_ptr), 32'(e.lp));
    chk("onehot", idx, 32'($countones(out_valid) <= 1), 32'd1);
  endtask
  initial begin
    logic [31:0] el;
    vec_t v;
    add(1, 0, 0, 0, 8'h00, 32'h00000000, 4'b0000, 0, 0);
    add(0, 1, 0, 2, 8'h5A, 32'h005A0000, 4'b0100, 0, 0);
    add(0, 0, 0, 0, 8'h00, 32'h005A0000, 4'b0000, 0, 0);
    add(0, 1, 1, 0, 8'h11, 32'h005A0011, 4'b0001, 0, 1);
    add(0, 1, 1, 0, 8'h22, 32'h005A2211, 4'b0010, 0, 2);
    add(0, 1, 1, 0, 8'h33, 32'h00332211, 4'b0100, 0, 3);
    add(0, 1, 1, 0, 8'h44, 32'h44332211, 4'b1000, 1, 0);
    add(0, 0, 1, 0, 8'h00, 32'h44332211, 4'b0000, 0, 0);
    add(0, 1, 1, 0, 8'hA1, 32'h443322A1, 4'b0001, 0, 1);
    add(0, 1, 1, 0, 8'hA2, 32'h4433A2A1, 4'b0010, 0, 2);
    add(0, 1, 0, 3, 8'hB0, 32'hB033A2A1, 4'b1000, 0, 0);
    add(0, 1, 1, 0, 8'hD0, 32'hB033A2D0, 4'b0001, 0, 1);
    add(0, 1, 1, 0, 8'hE1, 32'hB033E1D0, 4'b0010, 0, 2);
    add(0, 1, 1, 0, 8'hE2, 32'hB0E2E1D0, 4'b0100, 0, 3);
    add(1, 1, 1, 0, 8'hFF, 32'h00000000, 4'b0000, 0, 0);
    add(0, 1, 1, 0, 8'hC0, 32'h000000C0, 4'b0001, 0, 1);
    add(1, 0, 1, 0, 8'h00, 32'h00000000, 4'b0000, 0, 0);
    el = 32'd0;
    for (int k = 0; k < 8; k++) begin
      el[8*(k%4) +: 8] = 8'(k + 1);
      add(0, 1, 1, 0, 8'(k + 1), el, 4'(1 << (k % 4)), k % 4 == 3, 2'((k + 1) % 4));
      add(0, 0, 1, 0, 8'h00, el, 4'b0000, 0, 2'((k + 1) % 4));
    end
    foreach (tbl[i]) apply(tbl[i], i);
`ifdef DEMUX_FRAME_CNT_EN
    chk("frame_cnt_two", 0, 32'(frame_cnt), 32'd2);
`endif
    // 254 more back-to-back frames: 2 + 254 = 256 wraps the counter to 0
    for (int f = 0; f < 254; f++) begin
      for (int l = 0; l < 4; l++) begin
        el[8*l +: 8] = 8'(f + l);
        v.rst = 0; v.v = 1; v.m = 1; v.sel = 2'(3 - l); v.d = 8'(f + l);
        v.lanes = el; v.ov = 4'(1 << l); v.fd = l == 3; v.lp = 2'((l + 1) % 4);
        apply(v, 1000 + f);
      end
`ifdef DEMUX_FRAME_CNT_EN
      if (f == 252) chk("frame_cnt_255", f, 32'(frame_cnt), 32'd255);
      if (f == 253) chk("frame_cnt_wrap", f, 32'(frame_cnt), 32'd0);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/demux4_frame.md
DEMUX4_FRAME -- requirements
Module: demux4_frame

Interface
REQ-001 Parameter WIDTH, default 8, data width of the input and of each output lane.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies in_data for the current cycle.
REQ-005 in_data  input  WIDTH  sample to be routed.
REQ-006 sel  input  2  destination lane in direct mode; ignored in auto mode.
REQ-007 mode  input  1  0 = direct (sel-routed), 1 = auto (rotating lane pointer).
REQ-008 out0, out1, out2, out3  output  WIDTH each  per-lane hold registers.
REQ-009 out_valid  output  4  one-hot, one-cycle pulse marking the lane written in the previous cycle.
REQ-010 lane_ptr  output  2  current auto-mode lane pointer.
REQ-011 frame_done  output  1  one-cycle pulse when an auto-mode frame (lanes 0..3) completes.

Function
REQ-012 The block SHALL be the 1-to-4 counterpart of a 2:1 selector: each accepted sample goes to exactly one lane; non-selected lanes SHALL hold their values.
REQ-013 A sample SHALL be accepted only in cycles with in_valid=1; latency from acceptance to outN update and out_valid pulse SHALL be exactly 1 cycle.
REQ-014 Direct mode: accepted sample SHALL be written to lane sel; lane_ptr SHALL not change; frame_done SHALL stay 0.
REQ-015 Auto mode: accepted sample SHALL be written to lane lane_ptr, and lane_ptr SHALL increment by 1, wrapping 3 -> 0.
REQ-016 FSM states: IDLE (lane_ptr=0, no partial frame) and FILL (lane_ptr 1..3, partial frame held).
REQ-017 IDLE -> FILL on an accepted auto-mode sample; FILL -> FILL on accepted samples while lane_ptr<3; FILL -> IDLE on the accepted sample written to lane 3, with frame_done pulsing in the same cycle as that lane's out_valid.
REQ-018 in_valid=0 in any state SHALL leave state, lane_ptr, lanes and out_valid (all 0) unchanged/idle.
REQ-019 A mode change 1 -> 0 while in FILL SHALL abandon the partial frame: lane_ptr -> 0, state -> IDLE, no frame_done; already-written lanes keep their data.
REQ-020 A sample accepted in the same cycle as a mode change SHALL be routed per the new mode value.
REQ-021 out_valid SHALL never have more than one bit set.
REQ-022 Back-to-back samples (in_valid held 1) SHALL be accepted every cycle with no stall.

Reset
REQ-023 While rst=1 at a clock edge: out0..out3 = 0, out_valid = 0, lane_ptr = 0, frame_done = 0, state = IDLE; rst has priority over in_valid.
REQ-024 rst asserted mid-frame SHALL discard the partial frame with no frame_done pulse; first auto sample after rst release SHALL go to lane 0.

Configuration
REQ-025 Macro DEMUX_FRAME_CNT_EN: when defined, an extra output frame_cnt (8 bits) SHALL count frame_done pulses, reset to 0, wrap 255 -> 0; when undefined, the port and counter SHALL not exist and all other behaviour is identical.

Verification
REQ-026 Reset then direct mode, sel=2, in_data=0x5A, in_valid=1 for one cycle -> next cycle out2=0x5A, out_valid=4'b0100, other lanes 0, frame_done=0.
REQ-027 Auto mode, 4 back-to-back samples 0x11,0x22,0x33,0x44 -> out0..out3 = 0x11..0x44, out_valid 0001,0010,0100,1000 on consecutive cycles, frame_done=1 only with 1000, lane_ptr ends 0.
REQ-028 Auto mode, 2 samples (0xA1,0xA2), then mode=0 with sel=3, sample 0xB0 -> out3=0xB0, lane_ptr=0, no frame_done; next auto sample goes to lane 0.
REQ-029 Auto mode, 3 samples, rst=1 for one cycle -> all outputs 0, lane_ptr=0; following auto sample 0xC0 lands in out0.
REQ-030 Auto mode, samples with in_valid gaps (1,0,1,0,...) over 8 samples -> lane order 0,1,2,3,0,1,2,3, out_valid 0 in gap cycles, two frame_done pulses; with DEMUX_FRAME_CNT_EN, frame_cnt=2, and after 256 frames frame_cnt wraps to 0.
